sq_job_sequencer: RTL
=====================

SQ_JOB_SEQUENCER -- requirements
Module: sq_job_sequencer

Interface
REQ-001 SHALL have parameter SQ_W, default 1088, width of flattened redundant operand/result bus.
REQ-002 SHALL have parameter CNT_W, default 64, iteration-count width.
REQ-003 SHALL have parameter RST_CYC, default 4, squarer reset-pulse length in cycles (>=2).
REQ-004 SHALL have parameter TIMEOUT, default 1024, max cycles allowed between squarer results.
REQ-005 SHALL have port i_clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port i_rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have ports i_start_val input 1 / o_start_rdy output 1: job-request handshake.
REQ-008 SHALL have ports i_sq input SQ_W (start value) and i_iter input CNT_W (squarings requested), sampled on job accept.
REQ-009 SHALL have port i_abort, input, 1, cancels the active job.
REQ-010 SHALL have ports o_res output SQ_W, o_res_val output 1, i_res_rdy input 1: result handshake.
REQ-011 SHALL have ports o_busy output 1, o_err_timeout output 1 (sticky), o_iter_cnt output CNT_W (completed squarings).
REQ-012 SHALL have squarer-side ports o_sq_rst output 1, o_sq output SQ_W, o_sq_val output 1, i_sq_mul input SQ_W, i_sq_val input 1.

Function
REQ-013 SHALL implement one-hot FSM states IDLE, SQ_RST, LOAD, RUN, RESULT.
REQ-014 SHALL drive all outputs from registers; o_start_rdy = 1 only in IDLE; o_busy = 1 in SQ_RST, LOAD, RUN.
REQ-015 SHALL accept a job when i_start_val && o_start_rdy; latch i_sq into o_sq and the result register, latch i_iter, clear o_iter_cnt and o_err_timeout.
REQ-016 SHALL, on accept with i_iter == 0, go directly to RESULT with o_res = latched i_sq; squarer not started.
REQ-017 SHALL, on accept with i_iter != 0, enter SQ_RST and hold o_sq_rst = 1 for exactly RST_CYC cycles, then enter LOAD.
REQ-018 SHALL in LOAD drive o_sq_rst = 0 and o_sq_val = 1 for exactly one cycle, then enter RUN.
REQ-019 SHALL drive o_sq_rst = 1 in every state except LOAD and RUN, keeping the squarer quiescent.
REQ-020 SHALL in RUN, on each i_sq_val, latch i_sq_mul into the result register and increment o_iter_cnt; no wrap; at o_iter_cnt+1 == latched i_iter go to RESULT next cycle.
REQ-021 SHALL ignore i_sq_val in every state other than RUN.
REQ-022 SHALL count cycles since LOAD or last i_sq_val in RUN; on reaching TIMEOUT set o_err_timeout, go to IDLE, no result produced.
REQ-023 SHALL in RESULT hold o_res_val = 1 and o_res stable until i_res_rdy; on o_res_val && i_res_rdy return to IDLE next cycle.
REQ-024 SHALL, on i_abort in SQ_RST/LOAD/RUN/RESULT, go to IDLE next cycle, drop o_res_val, no error flag; i_abort in IDLE is ignored.
REQ-025 SHALL give priority abort > timeout > completion > i_sq_val counting when coincident in one cycle.
REQ-026 SHALL not accept a new job in the same cycle as a result handshake (o_start_rdy low in RESULT).

Reset
REQ-027 SHALL on i_rst asynchronously enter IDLE: o_start_rdy=1, o_sq_rst=1, o_sq_val=0, o_res_val=0, o_busy=0, o_err_timeout=0, o_iter_cnt=0, o_res=0, o_sq=0, watchdog=0.
REQ-028 SHALL, on reset asserted mid-job, discard the job; after release no result or i_sq_val effect from the old job is visible.

Verification (RST_CYC=4, TIMEOUT=64, SQ_W=16 model squarer returning x^2 mod 65521 after 10 cycles)
REQ-029 SHALL cover: accept i_sq=3, i_iter=3 -> o_sq_rst high 4 cycles, one o_sq_val with o_sq=3, o_res=6561, o_iter_cnt=3, o_res_val until i_res_rdy.
REQ-030 SHALL cover: i_iter=0, i_sq=0x1234 -> o_res_val next cycle with o_res=0x1234, o_sq_val never asserted.
REQ-031 SHALL cover: squarer stalls after 1 result -> o_err_timeout=1 64 cycles later, state IDLE, o_iter_cnt=1, no o_res_val; next accept clears flag.
REQ-032 SHALL cover: i_abort on same cycle as final i_sq_val -> IDLE, no o_res_val, o_err_timeout=0.
REQ-033 SHALL cover: i_res_rdy held low 20 cycles -> o_res constant, stray i_sq_val pulses ignored, o_iter_cnt unchanged.
REQ-034 SHALL cover: i_rst asserted during RUN -> outputs at REQ-027 values same cycle; new job after release completes normally.

Source files
------------

// File: rtl/sq_job_sequencer.sv
// Job sequencer for an external iterative squarer: it accepts a job, resets and
// loads the squarer, counts the returned squarings under a watchdog, and hands back the final value.
module sq_job_sequencer #(
  parameter int SQ_W    = 1088,
  parameter int CNT_W   = 64,
  parameter int RST_CYC = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start_val,
  output logic              o_start_rdy,
  input  logic [SQ_W-1:0]   i_sq,
  input  logic [CNT_W-1:0]  i_iter,
  input  logic              i_abort,
  output logic [SQ_W-1:0]   o_res,
  output logic              o_res_val,
  input  logic              i_res_rdy,
  output logic              o_busy,
  output logic              o_err_timeout,
  output logic [CNT_W-1:0]  o_iter_cnt,
  output logic              o_sq_rst,
  output logic [SQ_W-1:0]   o_sq,
  output logic              o_sq_val,
  input  logic [SQ_W-1:0]   i_sq_mul,
  input  logic              i_sq_val
);

  localparam int RC_W = $clog2(RST_CYC + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    SQ_RST = 5'b00010,
    LOAD   = 5'b00100,
    RUN    = 5'b01000,
    RESULT = 5'b10000
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] iter_tgt;
  logic [CNT_W-1:0] iter_nxt;
  logic [RC_W-1:0]  rst_cnt;
  logic [WD_W-1:0]  wdog;

  always_comb begin
    iter_nxt = o_iter_cnt + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      o_start_rdy   <= 1'b1;
      o_sq_rst      <= 1'b1;
      o_sq_val      <= 1'b0;
      o_res_val     <= 1'b0;
      o_busy        <= 1'b0;
      o_err_timeout <= 1'b0;
      o_iter_cnt    <= '0;
      o_res         <= '0;
      o_sq          <= '0;
      iter_tgt      <= '0;
      rst_cnt       <= '0;
      wdog          <= '0;
    end else begin
      o_sq_val <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start_val && o_start_rdy) begin
            o_sq          <= i_sq;
            o_res         <= i_sq;
            iter_tgt      <= i_iter;
            o_iter_cnt    <= '0;
            o_err_timeout <= 1'b0;
            o_start_rdy   <= 1'b0;
            rst_cnt       <= '0;
            if (i_iter == '0) begin
              state     <= RESULT;
              o_res_val <= 1'b1;
            end else begin
              state  <= SQ_RST;
              o_busy <= 1'b1;
            end
          end
        end

        SQ_RST: begin
          if (i_abort) begin
            state       <= IDLE;
            o_start_rdy <= 1'b1;
            o_busy      <= 1'b0;
            o_sq_rst    <= 1'b1;
            o_res_val   <= 1'b0;
          end else if (rst_cnt == RC_W'(RST_CYC - 1)) begin
            state    <= LOAD;
            o_sq_rst <= 1'b0;
            o_sq_val <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end

        LOAD: begin
          if (i_abort) begin
            state       <= IDLE;
            o_start_rdy <= 1'b1;
            o_busy      <= 1'b0;
            o_sq_rst    <= 1'b1;
            o_res_val   <= 1'b0;
          end else begin
            state <= RUN;
            wdog  <= '0;
          end
        end

        // Priority: abort, then watchdog expiry, then result counting/completion.
        RUN: begin
          if (i_abort) begin
            state       <= IDLE;
            o_start_rdy <= 1'b1;
            o_busy      <= 1'b0;
            o_sq_rst    <= 1'b1;
            o_res_val   <= 1'b0;
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            state         <= IDLE;
            o_start_rdy   <= 1'b1;
            o_busy        <= 1'b0;
            o_sq_rst      <= 1'b1;
            o_err_timeout <= 1'b1;
          end else if (i_sq_val) begin
            o_res      <= i_sq_mul;
            o_iter_cnt <= iter_nxt;
            wdog       <= '0;
            if (iter_nxt == iter_tgt) begin
              state     <= RESULT;
              o_busy    <= 1'b0;
              o_sq_rst  <= 1'b1;
              o_res_val <= 1'b1;
            end
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end

        RESULT: begin
          if (i_abort || (o_res_val && i_res_rdy)) begin
            state       <= IDLE;
            o_start_rdy <= 1'b1;
            o_res_val   <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          o_start_rdy <= 1'b1;
          o_busy      <= 1'b0;
          o_sq_rst    <= 1'b1;
          o_res_val   <= 1'b0;
        end
      endcase
    end
  end

endmodule
